fifo_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the 16x32 fifo block.
- Configurable width and depth.
- Independent push/pop strobes; simultaneous push and pop in the same cycle.
- Count output, almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Sits between producer and consumer stages on one clock domain; drop-in for existing fifo users once their READ/WRITE encoding is mapped to push/pop.

---
 rtl/fifo_param_if.sv | 33 +++
 rtl/fifo_param.sv | 99 +++++++++
 tb/tb_fifo_param.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Push/pop handshake, data and status bundle for fifo_param.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface fifo_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic              Cen;
    logic              push;
    logic              pop;
    logic              clr_err;
    logic [WIDTH-1:0]  Data_IN;
    logic [WIDTH-1:0]  Data_Out;
    logic [ADDR_W:0]   Count;
    logic              Empty;
    logic              Full;
    logic              Last;
    logic              Almost_Full;
    logic              Almost_Empty;
    logic              Overflow;
    logic              Underflow;

    modport master (
        output Cen, push, pop, clr_err, Data_IN,
        input  Data_Out, Count, Empty, Full, Last,
        input  Almost_Full, Almost_Empty, Overflow, Underflow
    );

    modport slave (
        input  Cen, push, pop, clr_err, Data_IN,
        output Data_Out, Count, Empty, Full, Last,
        output Almost_Full, Almost_Empty, Overflow, Underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with count, threshold flags and sticky error flags.
// Define FIFO_PARAM_FWFT_EN for first-word fall-through reads instead of a registered Data_Out.
module fifo_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         reset,
    fifo_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              empty;
    logic              full;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              udf_set;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);

    // A pop frees a slot in the same cycle, so push is accepted at Full when pop is.
    assign pop_ok  = bus.Cen & bus.pop & ~empty;
    assign push_ok = bus.Cen & bus.push & (~full | pop_ok);
    assign ovf_set = bus.Cen & bus.push & ~push_ok;
    assign udf_set = bus.Cen & bus.pop & empty;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.Cen) begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg     <= count_next;
            // New errors take priority over a clear in the same cycle.
            overflow_reg  <= (overflow_reg & ~bus.clr_err) | ovf_set;
            underflow_reg <= (underflow_reg & ~bus.clr_err) | udf_set;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= bus.Data_IN;
    end

`ifdef FIFO_PARAM_FWFT_EN
    assign bus.Data_Out = empty ? '0 : mem[rd_ptr_reg];
`else
    logic [WIDTH-1:0] data_out_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data_out_reg <= '0;
        else if (pop_ok)
            data_out_reg <= mem[rd_ptr_reg];
    end

    assign bus.Data_Out = data_out_reg;
`endif

    assign bus.Count        = count_reg;
    assign bus.Empty        = empty;
    assign bus.Full         = full;
    assign bus.Last         = (count_reg == LAST_C);
    assign bus.Almost_Full  = (count_reg >= AF_C);
    assign bus.Almost_Empty = (count_reg <= AE_C);
    assign bus.Overflow     = overflow_reg;
    assign bus.Underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_param.sv
// Directed vector bench for fifo_param (WIDTH=32, ADDR_W=4, AF=12, AE=2).
module tb_fifo_param;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fifo_param_if #(.WIDTH(32), .ADDR_W(4)) bus ();

    fifo_param #(
        .WIDTH(32), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cen;
        logic        push;
        logic        pop;
        logic        clr;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cen, input logic push, input logic pop, input logic clr,
                       input logic [31:0] din, input int cnt, input logic [31:0] dout,
                       input logic ovf, input logic udf);
        vec_t v;
        v.cen = cen; v.push = push; v.pop = pop; v.clr = clr; v.din = din;
        v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Flags packed as {Empty, Full, Last, Almost_Full, Almost_Empty, Overflow, Underflow}.
    function automatic logic [6:0] exp_flags(input int c, input logic ovf, input logic udf);
        return {c == 0, c == 16, c == 15, c >= 12, c <= 2, ovf, udf};
    endfunction

    function automatic logic [6:0] act_flags();
        return {bus.Empty, bus.Full, bus.Last, bus.Almost_Full, bus.Almost_Empty,
                bus.Overflow, bus.Underflow};
    endfunction

    task automatic check_state(input string tag, input int c, input logic [31:0] d,
                               input logic ovf, input logic udf, input bit chk_dout);
        cmp({tag, "_count"}, 32'(bus.Count), 32'(c));
        cmp({tag, "_flags"}, 32'(act_flags()), 32'(exp_flags(c, ovf, udf)));
        if (chk_dout)
            cmp({tag, "_dout"}, bus.Data_Out, d);
    endtask

    initial begin
        bit std_mode;
`ifdef FIFO_PARAM_FWFT_EN
        std_mode = 1'b0;
`else
        std_mode = 1'b1;
`endif
        checks = 0;
        errors = 0;
        bus.Cen = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
        bus.Data_IN = '0;

        // Basic push/pop, underflow and clear priority.
        add(1,1,0,0, 32'd1,   1, 32'd0, 0,0);
        add(1,1,0,0, 32'd2,   2, 32'd0, 0,0);
        add(1,1,0,0, 32'd3,   3, 32'd0, 0,0);
        add(1,0,1,0, 32'd0,   2, 32'd1, 0,0);
        add(1,0,1,0, 32'd0,   1, 32'd2, 0,0);
        add(1,0,1,0, 32'd0,   0, 32'd3, 0,0);
        add(1,0,1,0, 32'd0,   0, 32'd3, 0,1);
        add(1,0,0,1, 32'd0,   0, 32'd3, 0,0);
        add(1,0,1,1, 32'd0,   0, 32'd3, 0,1);
        add(1,0,0,1, 32'd0,   0, 32'd3, 0,0);
        add(1,1,1,0, 32'h55,  1, 32'd3, 0,1);
        add(1,0,1,1, 32'd0,   0, 32'h55, 0,0);
        // Fill, overflow, drain partially, refill across the wrap.
        for (int i = 0; i < 16; i++)
            add(1,1,0,0, 32'(i), i+1, 32'h55, 0,0);
        add(1,1,0,0, 32'hDEAD, 16, 32'h55, 1,0);
        add(1,0,0,1, 32'd0,   16, 32'h55, 0,0);
        for (int i = 0; i < 8; i++)
            add(1,0,1,0, 32'd0, 15-i, 32'(i), 0,0);
        for (int i = 0; i < 8; i++)
            add(1,1,0,0, 32'(100+i), 9+i, 32'd7, 0,0);
        add(1,1,1,0, 32'hFFFFFFFF, 16, 32'd8, 0,0);
        for (int i = 9; i < 16; i++)
            add(1,0,1,0, 32'd0, 24-i, 32'(i), 0,0);
        for (int i = 0; i < 8; i++)
            add(1,0,1,0, 32'd0, 8-i, 32'(100+i), 0,0);
        add(1,0,1,0, 32'd0,   0, 32'hFFFFFFFF, 0,0);
        // Cen freeze with toggling strobes.
        for (int i = 0; i < 5; i++)
            add(1,1,0,0, 32'(200+i), i+1, 32'hFFFFFFFF, 0,0);
        add(0,1,0,1, 32'hBAD0, 5, 32'hFFFFFFFF, 0,0);
        add(0,0,1,0, 32'hBAD1, 5, 32'hFFFFFFFF, 0,0);
        add(0,1,1,1, 32'hBAD2, 5, 32'hFFFFFFFF, 0,0);
        add(0,0,1,0, 32'hBAD3, 5, 32'hFFFFFFFF, 0,0);
        add(1,0,1,0, 32'd0,   4, 32'd200, 0,0);
        for (int i = 0; i < 5; i++)
            add(1,1,0,0, 32'(300+i), 5+i, 32'd200, 0,0);

        // Reset state.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_state("reset", 0, 32'd0, 0, 0, 1'b1);
        $display("txn reset count=%0d empty=%0b", bus.Count, bus.Empty);

        foreach (vecs[i]) begin
            bus.Cen = vecs[i].cen; bus.push = vecs[i].push; bus.pop = vecs[i].pop;
            bus.clr_err = vecs[i].clr; bus.Data_IN = vecs[i].din;
            @(posedge clk);
            #1;
            check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].dout,
                        vecs[i].ovf, vecs[i].udf, std_mode);
            $display("txn v%0d cen=%0b push=%0b pop=%0b din=%0h count=%0d dout=%0h",
                     i, vecs[i].cen, vecs[i].push, vecs[i].pop, vecs[i].din,
                     bus.Count, bus.Data_Out);
        end
        bus.Cen = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;

        // Asynchronous reset between edges at Count=9.
        cmp("pre_async_count", 32'(bus.Count), 32'd9);
        #2;
        reset = 1'b0;
        #1;
        check_state("async_rst", 0, 32'd0, 0, 0, 1'b1);
        $display("txn async_reset count=%0d dout=%0h", bus.Count, bus.Data_Out);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Push into empty FIFO: FWFT presents the word with no pop.
        bus.push = 1'b1; bus.Data_IN = 32'd42;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        @(posedge clk);
        #1;
`ifdef FIFO_PARAM_FWFT_EN
        check_state("fwft_42", 1, 32'd42, 0, 0, 1'b1);
        bus.pop = 1'b1;
        @(posedge clk);
        #1;
        bus.pop = 1'b0;
        check_state("fwft_pop", 0, 32'd0, 0, 0, 1'b1);
`else
        check_state("std_42", 1, 32'd0, 0, 0, 1'b1);
        bus.pop = 1'b1;
        @(posedge clk);
        #1;
        bus.pop = 1'b0;
        check_state("std_pop", 0, 32'd42, 0, 0, 1'b1);
`endif
        $display("txn push42 count=%0d dout=%0h", bus.Count, bus.Data_Out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
